rr_arb3_sel: RTL and testbench
==============================

RR_ARB3_SEL -- requirements
Module: rr_arb3_sel

Interface
REQ-001 SHALL have parameter IdleSel, default 2'b00, sel_o value driven while no grant is active.
REQ-002 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_i  input  3  per-requester request, bit n = requester n.
REQ-005 SHALL have port ready_i  input  1  downstream consumer ready.
REQ-006 SHALL have port gnt_o  output  3  one-hot grant, registered.
REQ-007 SHALL have port valid_o  output  1  granted data valid at downstream 3:1 mux output, registered.
REQ-008 SHALL have port sel_o  output  2  select code for the downstream two-stage 3:1 mux, registered.

Function
REQ-009 SHALL implement states IDLE (no grant) and GRANT (one requester granted).
REQ-010 SHALL encode sel_o so that requester 0 drives 2'b10, requester 1 drives 2'b11, requester 2 drives 2'b00; in IDLE, sel_o = IdleSel.
REQ-011 SHALL keep gnt_o one-hot in GRANT, all-zero in IDLE, and valid_o = |gnt_o at all times.
REQ-012 SHALL have a 2-bit priority pointer ptr_q (legal values 0..2); search order ptr_q, ptr_q+1, ptr_q+2 mod 3.
REQ-013 IDLE -> GRANT: any req_i bit high in cycle N SHALL give gnt_o/sel_o/valid_o for the winner in cycle N+1 (1-cycle latency).
REQ-014 Beat accepted when valid_o & ready_i; while valid_o & !ready_i, gnt_o and sel_o SHALL remain stable.
REQ-015 On acceptance of requester g, ptr_q SHALL become (g+1) mod 3, with wrap 2 -> 0.
REQ-016 On acceptance with another candidate request pending, SHALL grant the next winner in the following cycle with no idle bubble; with no request pending, SHALL return to IDLE.
REQ-017 If the granted requester deasserts req_i before acceptance, SHALL return to IDLE next cycle without moving ptr_q.
REQ-018 Simultaneous requests SHALL be resolved only by ptr_q; new requests arriving during GRANT SHALL NOT preempt the current grant.
REQ-019 sel_o and gnt_o SHALL never change in the same cycle as each other's stale value (both from the same register update).

Reset
REQ-020 rst_ni low SHALL immediately set state IDLE, gnt_o = 3'b000, valid_o = 0, sel_o = IdleSel, ptr_q = 0, including mid-grant.
REQ-021 First arbitration after reset release SHALL favour requester 0.

Configuration
REQ-022 With macro RR_ARB3_LOCK_EN defined, after acceptance the current requester SHALL keep the grant while its req_i bit stays high (multi-beat lock); ptr_q advances only when the grant is released.
REQ-023 Without RR_ARB3_LOCK_EN, SHALL re-arbitrate after every accepted beat per REQ-015/016.

Structure
REQ-024 Package arb3_pkg SHALL hold the sel code constants (SEL_I0 = 2'b10, SEL_I1 = 2'b11, SEL_I2 = 2'b00) and the state enum type.
REQ-025 SHALL instantiate one combinational sub-module arb3_rr_pick (req, ptr -> one-hot winner, any flag); all registers in rr_arb3_sel.

Verification
REQ-026 Reset, then req_i=3'b111, ready_i=1 for 6 cycles -> grant order 0,1,2,0,1,2 back-to-back, sel_o 10,11,00,10,11,00.
REQ-027 req_i=3'b100, ready_i=0 for 4 cycles then 1 -> gnt_o=3'b100, sel_o=00 stable 5 cycles, IDLE after accept.
REQ-028 Grant on requester 1 stalled, then req_i[1] dropped -> IDLE next cycle, next req_i=3'b011 grants requester 1 (ptr unchanged).
REQ-029 rst_ni asserted mid-grant -> outputs cleared same cycle, next req_i=3'b110 grants requester 1 first (ptr 0, 0 absent).
REQ-030 RR_ARB3_LOCK_EN defined, req_i=3'b011 held, ready_i=1 -> requester 0 holds grant until req_i[0] drops, then requester 1; without macro -> alternates 0,1,0,1.

Source files
------------

// File: rtl/arb3_pkg.sv
// Shared definitions for the 3-way round-robin arbiter: mux select codes and FSM states.
// No logic latency (types, constants and pure helper functions only).
// No flow control here; callers own all handshaking.
package arb3_pkg;

    localparam logic [1:0] SEL_I0 = 2'b10;
    localparam logic [1:0] SEL_I1 = 2'b11;
    localparam logic [1:0] SEL_I2 = 2'b00;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [1:0] gnt_idx(input logic [2:0] gnt);
        case (gnt)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] ptr_after(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Downstream two-stage mux decode; anything not one-hot parks the mux on idle_sel.
    function automatic logic [1:0] gnt_sel(input logic [2:0] gnt, input logic [1:0] idle_sel);
        case (gnt)
            3'b001:  return SEL_I0;
            3'b010:  return SEL_I1;
            3'b100:  return SEL_I2;
            default: return idle_sel;
        endcase
    endfunction

endpackage

// File: rtl/arb3_rr_pick.sv
// Round-robin winner picker: first set bit of req starting at ptr, wrapping mod 3.
// Purely combinational, zero latency.
// No backpressure; win is all-zero when no request is set.
module arb3_rr_pick (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] win,
    output logic       any
);

    always_comb begin
        win = 3'b000;
        any = |req;
        case (ptr)
            2'd1: begin
                if      (req[1]) win = 3'b010;
                else if (req[2]) win = 3'b100;
                else if (req[0]) win = 3'b001;
            end
            2'd2: begin
                if      (req[2]) win = 3'b100;
                else if (req[0]) win = 3'b001;
                else if (req[1]) win = 3'b010;
            end
            // ptr 3 is unreachable; treat it like 0 so the picker stays total
            default: begin
                if      (req[0]) win = 3'b001;
                else if (req[1]) win = 3'b010;
                else if (req[2]) win = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/rr_arb3_sel.sv
// 3-requester round-robin arbiter driving one-hot grant plus a 3:1 mux select; RR_ARB3_LOCK_EN enables multi-beat lock.
// 1-cycle request-to-grant latency; back-to-back grants on accept with no bubble.
// Grant and select hold stable while valid_o is high and ready_i is low.
module rr_arb3_sel
    import arb3_pkg::*;
#(
    parameter logic [1:0] IdleSel = 2'b00
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] req_i,
    input  logic       ready_i,
    output logic [2:0] gnt_o,
    output logic       valid_o,
    output logic [1:0] sel_o
);

    state_t     state_q;
    logic [2:0] gnt_q;
    logic [1:0] sel_q;
    logic       valid_q;
    logic [1:0] ptr_q;

    logic       accept;
    logic       cur_req;
    logic       rearb;
    logic [1:0] adv_ptr;
    logic [2:0] pick_req;
    logic [1:0] pick_ptr;
    logic [2:0] win;
    logic       win_any;

    assign accept  = valid_q & ready_i;
    assign cur_req = |(req_i & gnt_q);
    assign adv_ptr = ptr_after(gnt_idx(gnt_q));

`ifdef RR_ARB3_LOCK_EN
    // A locked requester keeps the grant across beats until its request drops.
    assign rearb = accept & ~cur_req;
`else
    assign rearb = accept;
`endif

    // On a re-arbitrating accept, the just-served requester is excluded and the
    // search starts one past it, so the next winner comes from "another" requester.
    always_comb begin
        pick_req = req_i;
        pick_ptr = ptr_q;
        if (state_q == GRANT && rearb) begin
            pick_req = req_i & ~gnt_q;
            pick_ptr = adv_ptr;
        end
    end

    arb3_rr_pick u_pick (
        .req (pick_req),
        .ptr (pick_ptr),
        .win (win),
        .any (win_any)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            sel_q   <= IdleSel;
            valid_q <= 1'b0;
            ptr_q   <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_any) begin
                        state_q <= GRANT;
                        gnt_q   <= win;
                        sel_q   <= gnt_sel(win, IdleSel);
                        valid_q <= 1'b1;
                    end
                end
                GRANT: begin
                    if (rearb) begin
                        ptr_q <= adv_ptr;
                        if (win_any) begin
                            gnt_q   <= win;
                            sel_q   <= gnt_sel(win, IdleSel);
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= 3'b000;
                            sel_q   <= IdleSel;
                            valid_q <= 1'b0;
                        end
                    end else if (!cur_req) begin
                        // Requester withdrew before its beat was taken: drop, keep pointer.
                        state_q <= IDLE;
                        gnt_q   <= 3'b000;
                        sel_q   <= IdleSel;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 3'b000;
                    sel_q   <= IdleSel;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o   = gnt_q;
    assign sel_o   = sel_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_rr_arb3_sel.sv
// Directed table-driven bench for rr_arb3_sel, plus reset and lock/alternation sequences.
// IdleSel is set to 2'b01 so an idle select is distinguishable from requester 2's code.
module tb_rr_arb3_sel;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic       ready;
    logic [2:0] gnt;
    logic       valid;
    logic [1:0] sel;

    int checks   = 0;
    int failures = 0;

    rr_arb3_sel #(.IdleSel(2'b01)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req),
        .ready_i (ready),
        .gnt_o   (gnt),
        .valid_o (valid),
        .sel_o   (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] req;
        logic       rdy;
        logic [2:0] gnt;
        logic [1:0] sel;
        logic       vld;
    } vec_t;

    task automatic check(input string name, input logic [2:0] eg, input logic [1:0] es, input logic ev);
        checks++;
        if ({gnt, sel, valid} !== {eg, es, ev}) begin
            failures++;
            $display("FAIL %s: got gnt=%b sel=%b valid=%b, want gnt=%b sel=%b valid=%b",
                     name, gnt, sel, valid, eg, es, ev);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[24];
    logic [2:0] alt_exp[4];
    logic [1:0] alt_sel[4];

    initial begin
        vecs[0]  = '{3'b111, 1'b1, 3'b001, 2'b10, 1'b1};
        vecs[1]  = '{3'b111, 1'b1, 3'b010, 2'b11, 1'b1};
        vecs[2]  = '{3'b111, 1'b1, 3'b100, 2'b00, 1'b1};
        vecs[3]  = '{3'b111, 1'b1, 3'b001, 2'b10, 1'b1};
        vecs[4]  = '{3'b111, 1'b1, 3'b010, 2'b11, 1'b1};
        vecs[5]  = '{3'b111, 1'b1, 3'b100, 2'b00, 1'b1};
        vecs[6]  = '{3'b000, 1'b1, 3'b000, 2'b01, 1'b0};
        vecs[7]  = '{3'b100, 1'b0, 3'b100, 2'b00, 1'b1};
        vecs[8]  = '{3'b100, 1'b0, 3'b100, 2'b00, 1'b1};
        vecs[9]  = '{3'b100, 1'b0, 3'b100, 2'b00, 1'b1};
        vecs[10] = '{3'b100, 1'b0, 3'b100, 2'b00, 1'b1};
        vecs[11] = '{3'b100, 1'b0, 3'b100, 2'b00, 1'b1};
        vecs[12] = '{3'b100, 1'b1, 3'b000, 2'b01, 1'b0};
        vecs[13] = '{3'b001, 1'b1, 3'b001, 2'b10, 1'b1};
        vecs[14] = '{3'b010, 1'b1, 3'b010, 2'b11, 1'b1};
        vecs[15] = '{3'b010, 1'b0, 3'b010, 2'b11, 1'b1};
        vecs[16] = '{3'b000, 1'b0, 3'b000, 2'b01, 1'b0};
        vecs[17] = '{3'b011, 1'b0, 3'b010, 2'b11, 1'b1};
        vecs[18] = '{3'b011, 1'b1, 3'b001, 2'b10, 1'b1};
        vecs[19] = '{3'b000, 1'b1, 3'b000, 2'b01, 1'b0};
        vecs[20] = '{3'b100, 1'b0, 3'b100, 2'b00, 1'b1};
        vecs[21] = '{3'b101, 1'b0, 3'b100, 2'b00, 1'b1};
        vecs[22] = '{3'b101, 1'b1, 3'b001, 2'b10, 1'b1};
        vecs[23] = '{3'b000, 1'b1, 3'b000, 2'b01, 1'b0};

`ifdef RR_ARB3_LOCK_EN
        for (int i = 0; i < 4; i++) begin
            alt_exp[i] = 3'b001;
            alt_sel[i] = 2'b10;
        end
`else
        for (int i = 0; i < 4; i++) begin
            alt_exp[i] = (i % 2 == 0) ? 3'b001 : 3'b010;
            alt_sel[i] = (i % 2 == 0) ? 2'b10 : 2'b11;
        end
`endif

        rst_n = 1'b0;
        req   = 3'b000;
        ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 3'b000, 2'b01, 1'b0);
        rst_n = 1'b1;

`ifndef RR_ARB3_LOCK_EN
        // Round-robin rotation, stall, withdraw and non-preemption rows.
        for (int i = 0; i < 24; i++) begin
            req   = vecs[i].req;
            ready = vecs[i].rdy;
            step();
            check($sformatf("row%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].vld);
        end
`endif

        // Drive pointer to 2 with requester 2 granted, then reset mid-grant.
        req = 3'b010; ready = 1'b1;
        step();
        check("pre_rst_g1", 3'b010, 2'b11, 1'b1);
        req = 3'b100; ready = 1'b1;
        step();
        check("pre_rst_g2", 3'b100, 2'b00, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("rst_async", 3'b000, 2'b01, 1'b0);
        #2;
        req = 3'b110; ready = 1'b0; rst_n = 1'b1;
        step();
        check("post_rst_g1", 3'b010, 2'b11, 1'b1);
        req = 3'b000; ready = 1'b1;
        step();
        check("post_rst_idle", 3'b000, 2'b01, 1'b0);

        // Two requesters held with ready high: alternation, or lock on requester 0.
        req = 3'b011; ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("hold011_%0d", i), alt_exp[i], alt_sel[i], 1'b1);
        end
        req = 3'b010;
        step();
`ifdef RR_ARB3_LOCK_EN
        check("drop0", 3'b010, 2'b11, 1'b1);
`else
        check("drop0", 3'b000, 2'b01, 1'b0);
`endif
        req = 3'b000;
        step();
        check("final_idle", 3'b000, 2'b01, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
